// File: rtl/para_frame_rx_if.sv
// Byte input and parsed-frame outputs of the MCU->FPGA frame parser.
// The UART side is the master; the parser is the slave.
interface para_frame_rx_if;
  logic [7:0]  rx_data;
  logic        rx_ok;
  logic [7:0]  ctrl_code;
  logic [31:0] payload;
  logic [2:0]  payload_len;
  logic        frame_valid;
  logic        para_set_flag;
  logic        para_enquire_flag;
  logic        crc_err;
  logic        fmt_err;
  logic        busy;
  logic [2:0]  fsm_state;

  // rx_ok is a level, not a valid/ready pair: every low->high transition is
  // one new byte, rx_data must be stable while rx_ok is high, there is no
  // back-pressure, and all result outputs are single-cycle pulses or holds.
  modport master (
    output rx_data, rx_ok,
    input  ctrl_code, payload, payload_len, frame_valid, para_set_flag,
           para_enquire_flag, crc_err, fmt_err, busy, fsm_state
  );

  modport slave (
    input  rx_data, rx_ok,
    output ctrl_code, payload, payload_len, frame_valid, para_set_flag,
           para_enquire_flag, crc_err, fmt_err, busy, fsm_state
  );
endinterface

// File: rtl/para_frame_rx.sv
// Frame parser for the MCU->FPGA UART link: START ctrl len_lo len_hi payload crc END.
// Define PARA_FRAME_RX_CRC_CHECK_EN to enable checksum comparison (crc_err stays 0 otherwise).
`ifndef FPGA_PACK_CMD_TYPE_START_CODE
`define FPGA_PACK_CMD_TYPE_START_CODE 8'h68
`endif
`ifndef FPGA_PACK_CMD_TYPE_END_CODE
`define FPGA_PACK_CMD_TYPE_END_CODE 8'h16
`endif

module para_frame_rx #(
  parameter logic [7:0] START_CODE  = `FPGA_PACK_CMD_TYPE_START_CODE,
  parameter logic [7:0] END_CODE    = `FPGA_PACK_CMD_TYPE_END_CODE,
  parameter int         MAX_PAYLOAD = 4,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  para_frame_rx_if.slave    bus
);

`ifdef PARA_FRAME_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [7:0]     MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL, S_LEN_L, S_LEN_H, S_PAY, S_CRC, S_END
  } state_t;

  state_t        state;
  logic [1:0]    rx_sync;
  logic          byte_stb;
  logic [7:0]    ctrl_w;
  logic [7:0]    len_lo;
  logic [31:0]   pay_w;
  logic [2:0]    idx;
  logic [7:0]    sum;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Synchroniser resets high so a line already high at reset release is not a byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], bus.rx_ok};
  end

  assign byte_stb      = rx_sync[0] & ~rx_sync[1];
  assign tmo_hit       = (state != S_IDLE) && (tmo_cnt == TMO_MAX);
  assign bus.busy      = (state != S_IDLE);
  assign bus.fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= S_IDLE;
      ctrl_w                <= '0;
      len_lo                <= '0;
      pay_w                 <= '0;
      idx                   <= '0;
      sum                   <= '0;
      tmo_cnt               <= '0;
      bus.ctrl_code         <= '0;
      bus.payload           <= '0;
      bus.payload_len       <= '0;
      bus.frame_valid       <= 1'b0;
      bus.para_set_flag     <= 1'b0;
      bus.para_enquire_flag <= 1'b0;
      bus.crc_err           <= 1'b0;
      bus.fmt_err           <= 1'b0;
    end else begin
      bus.frame_valid       <= 1'b0;
      bus.para_set_flag     <= 1'b0;
      bus.para_enquire_flag <= 1'b0;
      bus.crc_err           <= 1'b0;
      bus.fmt_err           <= 1'b0;

      if (state == S_IDLE || byte_stb) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)     tmo_cnt <= tmo_cnt + 1'b1;

      // A timeout coinciding with a byte drops that byte.
      if (tmo_hit) begin
        bus.fmt_err <= 1'b1;
        state       <= S_IDLE;
      end else if (byte_stb) begin
        case (state)
          S_IDLE: if (bus.rx_data == START_CODE) state <= S_CTRL;
          S_CTRL: begin
            ctrl_w <= bus.rx_data;
            sum    <= bus.rx_data;
            state  <= S_LEN_L;
          end
          S_LEN_L: begin
            len_lo <= bus.rx_data;
            sum    <= sum + bus.rx_data;
            state  <= S_LEN_H;
          end
          S_LEN_H: begin
            sum   <= sum + bus.rx_data;
            pay_w <= '0;
            idx   <= '0;
            if (bus.rx_data != 8'h00 || len_lo > MAX_LEN) begin
              bus.fmt_err <= 1'b1;
              state       <= S_IDLE;
            end else if (len_lo == 8'h00) begin
              state <= S_CRC;
            end else begin
              state <= S_PAY;
            end
          end
          S_PAY: begin
            pay_w[{idx[1:0], 3'b000} +: 8] <= bus.rx_data;
            sum <= sum + bus.rx_data;
            idx <= idx + 3'd1;
            if ((idx + 3'd1) == len_lo[2:0]) state <= S_CRC;
          end
          S_CRC: begin
            if (CRC_EN && (bus.rx_data != ~sum)) begin
              bus.crc_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_END;
            end
          end
          S_END: begin
            state <= S_IDLE;
            if (bus.rx_data == END_CODE) begin
              bus.ctrl_code         <= ctrl_w;
              bus.payload           <= pay_w;
              bus.payload_len       <= len_lo[2:0];
              bus.frame_valid       <= 1'b1;
              bus.para_set_flag     <= (len_lo != 8'h00);
              bus.para_enquire_flag <= (len_lo == 8'h00);
            end else begin
              bus.fmt_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
